// File: rtl/openram_bist_pkg.sv
// Shared types and constants for the openram March C- BIST sequencer: FSM states,
// LA packet field positions and the march element table.
package openram_bist_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StClkHi,
      StClkLo,
      StClk2Hi,
      StClk2Lo,
      StCmp,
      StDone
   } bist_state_e;

   localparam int unsigned PktW      = 112;
   localparam int unsigned SelMsb    = 111;
   localparam int unsigned SelLsb    = 108;
   localparam int unsigned Addr0Msb  = 107;
   localparam int unsigned Addr0Lsb  = 92;
   localparam int unsigned Din0Msb   = 91;
   localparam int unsigned Din0Lsb   = 60;
   localparam int unsigned Csb0Bit   = 59;
   localparam int unsigned Web0Bit   = 58;
   localparam int unsigned Wmask0Msb = 57;
   localparam int unsigned Wmask0Lsb = 54;
   localparam int unsigned Addr1Msb  = 53;
   localparam int unsigned Addr1Lsb  = 38;
   localparam int unsigned Din1Msb   = 37;
   localparam int unsigned Din1Lsb   = 6;
   localparam int unsigned Csb1Bit   = 5;
   localparam int unsigned Web1Bit   = 4;
   localparam int unsigned Wmask1Msb = 3;
   localparam int unsigned Wmask1Lsb = 0;

   localparam int unsigned ErrCntW  = 16;
   localparam logic [2:0]  LastElem = 3'd5;

   // Bit i of is_read/inv describes op i of the element; inv selects ~bg_pattern.
   typedef struct packed {
      logic       down;
      logic [1:0] n_ops;
      logic [1:0] is_read;
      logic [1:0] inv;
   } march_elem_t;

   function automatic march_elem_t march_elem(input logic [2:0] idx);
      march_elem_t e;
      case (idx)
         3'd0:    e = '{down: 1'b0, n_ops: 2'd1, is_read: 2'b00, inv: 2'b00}; // up W0
         3'd1:    e = '{down: 1'b0, n_ops: 2'd2, is_read: 2'b01, inv: 2'b10}; // up R0,W1
         3'd2:    e = '{down: 1'b0, n_ops: 2'd2, is_read: 2'b01, inv: 2'b01}; // up R1,W0
         3'd3:    e = '{down: 1'b1, n_ops: 2'd2, is_read: 2'b01, inv: 2'b10}; // down R0,W1
         3'd4:    e = '{down: 1'b1, n_ops: 2'd2, is_read: 2'b01, inv: 2'b01}; // down R1,W0
         default: e = '{down: 1'b1, n_ops: 2'd1, is_read: 2'b01, inv: 2'b00}; // down R0
      endcase
      return e;
   endfunction

endpackage

// File: rtl/openram_bist_addr_gen.sv
// Up/down address counter for the march sequencer; last_o flags the final address
// of the current sweep direction.
module openram_bist_addr_gen #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  load_first_i,
   input  logic                  dir_i,
   input  logic                  step_i,
   output logic [ADDR_WIDTH-1:0] addr_nxt_o,
   output logic                  last_o
);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  dir_q, dir_d;

   // Direction is latched on load so last_o never depends on this cycle's dir_i.
   always_comb begin
      addr_d = addr_q;
      dir_d  = dir_q;
      if (load_first_i) begin
         dir_d  = dir_i;
         addr_d = dir_i ? '1 : '0;
      end else if (step_i) begin
         addr_d = dir_q ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         addr_q <= '0;
         dir_q  <= 1'b0;
      end else begin
         addr_q <= addr_d;
         dir_q  <= dir_d;
      end
   end

   assign addr_nxt_o = addr_d;
   assign last_o     = dir_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/openram_march_bist.sv
// March C- self-test sequencer driving the openram_testchip LA command interface.
// Optional BIST_PORT1_CHECK_EN also reads and checks port 1 on every read op.
module openram_march_bist
   import openram_bist_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [3:0]  SRAM_SEL   = 4'd0
) (
   input  logic               la_clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        bg_pattern,
   input  logic [31:0]        la_data0,
   input  logic [31:0]        la_data1,
   output logic [PktW-1:0]    la_bits,
   output logic               la_in_load,
   output logic               la_sram_load,
   output logic               la_sram_clk,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [15:0]        fail_addr,
   output logic [31:0]        fail_data,
   output logic [ErrCntW-1:0] err_count
);

   bist_state_e state_q, state_d;
   logic [2:0]  elem_q, elem_d;
   logic        op_q, op_d;
   logic [31:0] bg_q, bg_d;
   logic [31:0] exp_q;
   logic        rd_q;

   march_elem_t cur_e, nxt_e;
   logic        op_last, op_end, load_pkt, nxt_rd, mis0, mis1;
   logic [31:0] nxt_word;
   logic [15:0] addr16;
   logic [PktW-1:0] pkt;

   logic        fail_d;
   logic [15:0] fail_addr_d;
   logic [31:0] fail_data_d;
   logic [ErrCntW-1:0] err_count_d;

   logic                  addr_load, addr_step, addr_dir, addr_last;
   logic [ADDR_WIDTH-1:0] addr_nxt;

   openram_bist_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i       (la_clk),
      .reset_i     (reset),
      .load_first_i(addr_load),
      .dir_i       (addr_dir),
      .step_i      (addr_step),
      .addr_nxt_o  (addr_nxt),
      .last_o      (addr_last)
   );

   always_comb begin
      cur_e       = march_elem(elem_q);
      op_last     = ({1'b0, op_q} == (cur_e.n_ops - 2'd1));
      op_end      = ((state_q == StClkLo) && !rd_q) || (state_q == StCmp);
      state_d     = state_q;
      elem_d      = elem_q;
      op_d        = op_q;
      bg_d        = bg_q;
      addr_load   = 1'b0;
      addr_step   = 1'b0;
      load_pkt    = 1'b0;
      fail_d      = fail;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;
      err_count_d = err_count;
      mis0        = (la_data0 != exp_q);
`ifdef BIST_PORT1_CHECK_EN
      mis1        = (la_data1 != exp_q);
`else
      mis1        = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StLoad;
               elem_d      = '0;
               op_d        = 1'b0;
               addr_load   = 1'b1;
               bg_d        = bg_pattern;
               load_pkt    = 1'b1;
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
               err_count_d = '0;
            end
         end
         StLoad:   state_d = StClkHi;
         StClkHi:  state_d = StClkLo;
         StClkLo:  if (rd_q) state_d = StClk2Hi;
         StClk2Hi: state_d = StClk2Lo;
         StClk2Lo: state_d = StCmp;
         StCmp: begin
            if (mis0 || mis1) begin
               fail_d = 1'b1;
               if (err_count != '1) err_count_d = err_count + ErrCntW'(1);
               if (!fail) begin
                  fail_addr_d = la_bits[Addr0Msb:Addr0Lsb];
                  fail_data_d = mis0 ? la_data0 : la_data1;
               end
            end
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      if (op_end) begin
         if ((elem_q == LastElem) && op_last && addr_last) begin
            state_d = StDone;
         end else begin
            state_d  = StLoad;
            load_pkt = 1'b1;
            if (!op_last) begin
               op_d = op_q + 1'b1;
            end else begin
               op_d = 1'b0;
               if (addr_last) begin
                  elem_d    = elem_q + 3'd1;
                  addr_load = 1'b1;
               end else begin
                  addr_step = 1'b1;
               end
            end
         end
      end

      // Packet for the op about to start, built from next-state counters.
      nxt_e    = march_elem(elem_d);
      addr_dir = nxt_e.down;
      nxt_rd   = nxt_e.is_read[op_d];
      nxt_word = nxt_e.inv[op_d] ? ~bg_d : bg_d;
      addr16   = '0;
      addr16[ADDR_WIDTH-1:0] = addr_nxt;

      pkt = '0;
      pkt[SelMsb:SelLsb]     = SRAM_SEL;
      pkt[Addr0Msb:Addr0Lsb] = addr16;
      pkt[Csb0Bit]           = 1'b0;
      pkt[Csb1Bit]           = 1'b1;
      pkt[Web1Bit]           = 1'b1;
      if (nxt_rd) begin
         pkt[Web0Bit] = 1'b1;
`ifdef BIST_PORT1_CHECK_EN
         pkt[Csb1Bit]           = 1'b0;
         pkt[Addr1Msb:Addr1Lsb] = addr16;
`endif
      end else begin
         pkt[Din0Msb:Din0Lsb]     = nxt_word;
         pkt[Wmask0Msb:Wmask0Lsb] = 4'hF;
      end
   end

   always_ff @(posedge la_clk) begin
      if (reset) begin
         state_q      <= StIdle;
         elem_q       <= '0;
         op_q         <= 1'b0;
         bg_q         <= '0;
         exp_q        <= '0;
         rd_q         <= 1'b0;
         la_bits      <= '0;
         la_in_load   <= 1'b0;
         la_sram_load <= 1'b0;
         la_sram_clk  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fail         <= 1'b0;
         fail_addr    <= '0;
         fail_data    <= '0;
         err_count    <= '0;
      end else begin
         state_q      <= state_d;
         elem_q       <= elem_d;
         op_q         <= op_d;
         bg_q         <= bg_d;
         la_in_load   <= (state_d == StLoad);
         la_sram_load <= (state_d inside {StClkHi, StClkLo, StClk2Hi, StClk2Lo});
         la_sram_clk  <= (state_d == StClkHi) || (state_d == StClk2Hi);
         busy         <= !(state_d inside {StIdle, StDone});
         done         <= (state_d == StDone);
         fail         <= fail_d;
         fail_addr    <= fail_addr_d;
         fail_data    <= fail_data_d;
         err_count    <= err_count_d;
         if (load_pkt) begin
            la_bits <= pkt;
            exp_q   <= nxt_word;
            rd_q    <= nxt_rd;
         end
      end
   end

endmodule

// File: tb/tb_openram_march_bist.sv
// Self-checking bench for openram_march_bist with a behavioural SRAM and a
// packet/result scoreboard fed by an independent March C- model.
module tb_openram_march_bist;

   localparam int AW = 2;
   localparam int W  = 1 << AW;

   typedef struct {
      logic        fail;
      logic [15:0] addr;
      logic [31:0] data;
      logic [15:0] errs;
      int          busy;
      int          clks;
   } res_t;

   logic          la_clk = 1'b0;
   logic          reset, start;
   logic [31:0]   bg_pattern;
   logic [31:0]   la_data0 = '0;
   logic [31:0]   la_data1 = '0;
   logic [111:0]  la_bits;
   logic          la_in_load, la_sram_load, la_sram_clk, busy, done, fail;
   logic [15:0]   fail_addr;
   logic [31:0]   fail_data;
   logic [15:0]   err_count;

   logic [31:0]   sram [W];
   logic [15:0]   stuck_addr;
   logic [31:0]   stuck_mask;
   bit            p1_corrupt;
   int            p1_strobes = 0;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            busy_cnt, clk_cnt;
   bit            done_seen;
   logic [111:0]  pkt_q [$];
   res_t          res_q [$];

   openram_march_bist #(
      .ADDR_WIDTH(AW),
      .SRAM_SEL  (4'd0)
   ) dut (
      .la_clk      (la_clk),
      .reset       (reset),
      .start       (start),
      .bg_pattern  (bg_pattern),
      .la_data0    (la_data0),
      .la_data1    (la_data1),
      .la_bits     (la_bits),
      .la_in_load  (la_in_load),
      .la_sram_load(la_sram_load),
      .la_sram_clk (la_sram_clk),
      .busy        (busy),
      .done        (done),
      .fail        (fail),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data),
      .err_count   (err_count)
   );

   always #5 la_clk = ~la_clk;

   // Behavioural SRAM reacting to each strobe; optional stuck bits and port-1 corruption.
   always @(posedge la_clk) begin
      if (start) p1_strobes <= 0;
      if (la_sram_clk && la_sram_load) begin
         if (!la_bits[59]) begin
            if (!la_bits[58]) sram[la_bits[92 +: AW]] <= la_bits[91:60];
            else la_data0 <= sram[la_bits[92 +: AW]] |
                             ((la_bits[107:92] == stuck_addr) ? stuck_mask : 32'h0);
         end
         if (!la_bits[5] && la_bits[4]) begin
            if (p1_corrupt && p1_strobes < 2) la_data1 <= 32'hDEADBEEF;
            else la_data1 <= sram[la_bits[38 +: AW]] |
                             ((la_bits[53:38] == stuck_addr) ? stuck_mask : 32'h0);
            p1_strobes <= p1_strobes + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bits"}, la_bits, 0);
      check({tag, "_strobes"}, {la_in_load, la_sram_load, la_sram_clk}, 0);
      check({tag, "_busy_done"}, {busy, done}, 0);
      check({tag, "_fail"}, fail, 0);
      check({tag, "_fail_addr"}, fail_addr, 0);
      check({tag, "_fail_data"}, fail_data, 0);
      check({tag, "_err_count"}, err_count, 0);
   endtask

   // One clock of monitoring: packet and strobe checks, result pop at done.
   task automatic tick();
      logic [111:0] p;
      res_t r;
      @(negedge la_clk);
      if (reset) begin
         pkt_q.delete();
         busy_cnt = 0;
         clk_cnt  = 0;
      end else begin
         if (la_in_load) begin
            check("pkt_avail", pkt_q.size() > 0, 1);
            check("load_strobes", {la_sram_load, la_sram_clk}, 0);
            if (pkt_q.size() > 0) begin
               p = pkt_q.pop_front();
               check("pkt", la_bits, p);
            end
         end
         if (la_sram_clk) check("clk_in_drive", la_sram_load, 1);
         if (busy) busy_cnt++;
         if (la_sram_clk) clk_cnt++;
         if (done) begin
            done_seen = 1;
            check("done_not_busy", busy, 0);
            check("res_avail", res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
               r = res_q.pop_front();
               check("fail", fail, r.fail);
               check("fail_addr", fail_addr, r.addr);
               check("fail_data", fail_data, r.data);
               check("err_count", err_count, r.errs);
               check("busy_cycles", busy_cnt, r.busy);
               check("sram_clks", clk_cnt, r.clks);
            end
            busy_cnt = 0;
            clk_cnt  = 0;
         end
      end
   endtask

   // Independent March C- model producing expected packets and the final result.
   task automatic expect_run(input logic [31:0] bgp, input logic [15:0] sa,
                             input logic [31:0] sm, input bit p1c, input bit push_res);
      logic [31:0]  mem [W];
      logic [31:0]  word, d0, d1;
      logic [111:0] p;
      logic [15:0]  a16;
      bit           m0, m1, first_rd;
      int           a;
      res_t         r;
      int           nops [6];
      bit           down [6];
      bit           rd   [6][2];
      bit           inv  [6][2];
      nops = '{1, 2, 2, 2, 2, 1};
      down = '{0, 0, 0, 1, 1, 1};
      rd   = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
      inv  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
      r.fail = 0; r.addr = 0; r.data = 0; r.errs = 0;
      r.busy = 45 * W;
      r.clks = 15 * W;
      first_rd = 1;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < W; k++) begin
            a   = down[e] ? (W - 1 - k) : k;
            a16 = 16'(a);
            for (int o = 0; o < nops[e]; o++) begin
               word = inv[e][o] ? ~bgp : bgp;
               p = '0;
               p[107:92] = a16;
               p[5] = 1'b1;
               p[4] = 1'b1;
               if (rd[e][o]) begin
                  p[58] = 1'b1;
`ifdef BIST_PORT1_CHECK_EN
                  p[5]     = 1'b0;
                  p[53:38] = a16;
`endif
                  d0 = mem[a] | ((a16 == sa) ? sm : 32'h0);
                  d1 = (p1c && first_rd) ? 32'hDEADBEEF : d0;
                  first_rd = 0;
                  m0 = (d0 != word);
`ifdef BIST_PORT1_CHECK_EN
                  m1 = (d1 != word);
`else
                  m1 = 0;
`endif
                  if (m0 || m1) begin
                     if (!r.fail) begin
                        r.addr = a16;
                        r.data = m0 ? d0 : d1;
                     end
                     r.fail = 1;
                     if (r.errs != 16'hFFFF) r.errs = r.errs + 16'd1;
                  end
               end else begin
                  p[91:60] = word;
                  p[57:54] = 4'hF;
                  mem[a]   = word;
               end
               pkt_q.push_back(p);
            end
         end
      end
      if (push_res) res_q.push_back(r);
   endtask

   task automatic launch(input logic [31:0] bgp, input bit first_chk);
      logic [111:0] first_pkt;
      first_pkt = {4'd0, 16'd0, 32'd0, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'd0};
      tick();
      done_seen  = 0;
      bg_pattern = bgp;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      check("busy_after_start", {busy, la_in_load}, 2'b11);
      if (first_chk) check("first_pkt", la_bits, first_pkt);
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && !done_seen; i++) tick();
      check("done_seen", done_seen, 1);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      bg_pattern = '0;
      stuck_addr = '0;
      stuck_mask = '0;
      p1_corrupt = 0;
      busy_cnt   = 0;
      clk_cnt    = 0;
      done_seen  = 0;
      repeat (3) @(posedge la_clk);
      #1;
      check_reset_outputs("por");
      tick();
      reset = 1'b0;

      // Clean pass with all-zero background.
      expect_run(32'h0, 16'h0, 32'h0, 0, 1);
      launch(32'h0, 1);
      wait_done(400);

      // Bit 0 of word 2 stuck at 1; a start mid-run must be ignored.
      stuck_addr = 16'd2;
      stuck_mask = 32'h1;
      expect_run(32'h0, 16'd2, 32'h1, 0, 1);
      launch(32'h0, 0);
      repeat (50) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(400);
      check("stuck_fail", fail, 1);
      check("stuck_addr", fail_addr, 16'd2);
      check("stuck_data", fail_data, 32'h1);
      check("stuck_errs", err_count, 16'd3);
      repeat (3) tick();
      check("stuck_hold", {fail, err_count}, {1'b1, 16'd3});

      // Restart without the fault clears the sticky results.
      stuck_mask = 32'h0;
      expect_run(32'h5A5AC3C3, 16'd2, 32'h0, 0, 1);
      launch(32'h5A5AC3C3, 0);
      wait_done(400);
      check("restart_clean", {fail, err_count}, 17'h0);

      // Stuck-at-1 under an all-ones background only trips the R1 reads.
      stuck_addr = 16'd1;
      stuck_mask = 32'h1;
      expect_run(32'hFFFFFFFF, 16'd1, 32'h1, 0, 1);
      launch(32'hFFFFFFFF, 0);
      wait_done(400);
      stuck_mask = 32'h0;

      // Reset while the first strobe is high.
      expect_run(32'h0, 16'd0, 32'h0, 0, 0);
      launch(32'h0, 0);
      for (int i = 0; i < 20 && !la_sram_clk; i++) tick();
      check("midrun_clk_hi", la_sram_clk, 1);
      reset = 1'b1;
      @(posedge la_clk);
      #1;
      check_reset_outputs("midrun");
      tick();
      tick();
      reset = 1'b0;
      expect_run(32'h12345678, 16'd0, 32'h0, 0, 1);
      launch(32'h12345678, 0);
      wait_done(400);

`ifdef BIST_PORT1_CHECK_EN
      p1_corrupt = 1;
      expect_run(32'h0, 16'd0, 32'h0, 1, 1);
      launch(32'h0, 0);
      wait_done(400);
      p1_corrupt = 0;
      check("p1_fail", fail, 1);
      check("p1_data", fail_data, 32'hDEADBEEF);
      check("p1_errs", err_count, 16'd1);
`endif

      check("sb_pkts_left", pkt_q.size(), 0);
      check("sb_res_left", res_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
